// File: rtl/excess3_to_bcd_packer.sv
// Receive-side excess-3 decoder: collects one digit per handshake, MSD first,
// and presents a right-justified packed BCD frame with digit count and error flag.
module excess3_to_bcd_packer #(
  parameter  int DIGITS = 4,
  localparam int CW     = $clog2(DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            e,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [CW-1:0]         ndig,
  output logic                  err
);

  localparam int W = 4 * DIGITS;

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t        state, state_next;
  logic [W-1:0]  acc;
  logic [CW-1:0] cnt;
  logic          err_acc;

  logic          accept;
  logic [3:0]    digit;
  logic          illegal;
  logic [W-1:0]  acc_shift;
  logic [CW-1:0] cnt_inc;
  logic          close;

  // Illegal codes decode to 4'hF so the bad position stays visible in the frame.
  function automatic logic [4:0] decode_e3(input logic [3:0] code);
    if (code >= 4'd3 && code <= 4'd12) return {1'b0, code - 4'd3};
    else                               return {1'b1, 4'hF};
  endfunction

  assign {illegal, digit} = decode_e3(e);
  assign accept    = in_valid && in_ready;
  assign acc_shift = (acc << 4) | W'(digit);
  assign cnt_inc   = cnt + CW'(1);
  assign close     = accept && (in_last || cnt_inc == CW'(DIGITS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (close)     state_next = HOLD;
      HOLD:    if (out_ready) state_next = COLLECT;
      default:                state_next = COLLECT;
    endcase
  end

  // Handshake outputs depend on state only, never on in_valid/out_ready.
  always_comb begin
    in_ready  = (state == COLLECT);
    out_valid = (state == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      err_acc <= 1'b0;
      bcd     <= '0;
      ndig    <= '0;
      err     <= 1'b0;
    end else if (accept) begin
      acc     <= acc_shift;
      cnt     <= cnt_inc;
      err_acc <= err_acc | illegal;
      if (close) begin
        bcd  <= acc_shift;
        ndig <= cnt_inc;
        err  <= err_acc | illegal;
      end
    end else if (state == HOLD && out_ready) begin
      acc     <= '0;
      cnt     <= '0;
      err_acc <= 1'b0;
    end
  end

endmodule

// File: tb/tb_excess3_to_bcd_packer.sv
// Directed bench for excess3_to_bcd_packer (DIGITS=4) with hand-computed frames.
module tb_excess3_to_bcd_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  e = 4'd0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] bcd;
  logic [2:0]  ndig;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  excess3_to_bcd_packer #(.DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .e(e), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .bcd(bcd), .ndig(ndig), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a digit just after a rising edge; returns 1 ns after the accepting edge.
  task automatic send(input logic [3:0] code, input logic last);
    bit ok = 1'b0;
    in_valid = 1'b1;
    e        = code;
    in_last  = last;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    check("send_accept", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_frame(input string tag, input logic [15:0] b, input logic [2:0] n, input logic er);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_bcd"},   {16'd0, bcd},       {16'd0, b});
    check({tag, "_ndig"},  {29'd0, ndig},      {29'd0, n});
    check({tag, "_err"},   {31'd0, err},       {31'd0, er});
  endtask

  task automatic drain;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    // Asynchronous reset with no clock edge in between.
    #3 rst_n = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_bcd",       {16'd0, bcd},       32'd0);
    check("rst_ndig",      {29'd0, ndig},      32'd0);
    check("rst_err",       {31'd0, err},       32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Full frame with out_ready held high.
    out_ready = 1'b1;
    send(4'b0100, 1'b0);
    send(4'b0111, 1'b0);
    send(4'b1010, 1'b0);
    send(4'b1100, 1'b0);
    expect_frame("full", 16'h1479, 3'd4, 1'b0);
    check("full_in_ready_hold", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    check("full_valid_drop", {31'd0, out_valid}, 32'd0);
    check("full_in_ready_back", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b0;

    // Short frame closed by in_last.
    send(4'b1000, 1'b0);
    send(4'b0011, 1'b1);
    expect_frame("short", 16'h0050, 3'd2, 1'b0);
    drain();

    // Illegal code marks its nibble and sets the sticky error.
    send(4'b0101, 1'b0);
    send(4'b1101, 1'b0);
    send(4'b0110, 1'b1);
    expect_frame("illegal", 16'h02F3, 3'd3, 1'b1);
    drain();
    send(4'b0011, 1'b1);
    expect_frame("after_illegal", 16'h0000, 3'd1, 1'b0);
    drain();

    // in_last on the fourth digit closes exactly one frame.
    send(4'b1100, 1'b0);
    send(4'b1011, 1'b0);
    send(4'b1010, 1'b0);
    send(4'b1001, 1'b1);
    expect_frame("last_at_max", 16'h9876, 3'd4, 1'b0);
    drain();
    @(negedge clk);
    check("last_at_max_single", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;

    // Backpressure: pending digit must not be consumed while holding.
    send(4'b0111, 1'b1);
    in_valid = 1'b1;
    e        = 4'b1011;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", {31'd0, in_ready},  32'd0);
      check("bp_valid",    {31'd0, out_valid}, 32'd1);
      check("bp_bcd",      {16'd0, bcd},       32'h0004);
      check("bp_ndig",     {29'd0, ndig},      32'd1);
      check("bp_err",      {31'd0, err},       32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_no_bypass_valid", {31'd0, out_valid}, 32'd0);
    check("bp_collect_ready",   {31'd0, in_ready},  32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    expect_frame("bp_next", 16'h0008, 3'd1, 1'b0);
    drain();

    // Reset mid-frame discards partial digits.
    send(4'b0100, 1'b0);
    send(4'b0101, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mrst_bcd",       {16'd0, bcd},       32'd0);
    check("mrst_ndig",      {29'd0, ndig},      32'd0);
    check("mrst_err",       {31'd0, err},       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(4'b1100, 1'b1);
    expect_frame("mrst_next", 16'h0009, 3'd1, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
